datapath: RTL and testbench



---
 rtl/datapath.sv | 99 +++++++++
 tb/tb_datapath.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: 32-bit single-bus register-transfer slice.
// Holds R1-R3, PC, IR, Y, 64-bit Z, HI and MDR around one shared bus
// and a bitwise-AND ALU feeding Z. All strobes come from an external sequencer.
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        MDRin,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        ZHighout,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        Yin,
  input  logic        IRin,
  input  logic        HIin,
  input  logic        AND,
  output logic [31:0] BusMuxOut,
  output logic [31:0] R1_q,
  output logic [31:0] R2_q,
  output logic [31:0] R3_q,
  output logic [31:0] IR_q,
  output logic [31:0] HI_q
);

  logic [31:0] r1, r2, r3, pc, ir, y, hi, mdr;
  logic [63:0] z;
  logic [31:0] bus;
  logic [31:0] alu_and;

  // Bus source select; fixed priority when several drive strobes are high
  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr;
    else if (R2out)    bus = r2;
    else if (R3out)    bus = r3;
    else if (PCout)    bus = pc;
    else if (Zlowout)  bus = z[31:0];
    else if (ZHighout) bus = z[63:32];
  end

  // ALU: bitwise AND of Y with the current bus value
  always_comb begin
    alu_and = y & bus;
  end

  // MDR: loads either memory read data or the bus
  always_ff @(posedge clock or posedge clear) begin
    if (clear)      mdr <= '0;
    else if (MDRin) mdr <= Read ? Mdatain : bus;
  end

  // General and special registers loading from the bus
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      y  <= '0;
      ir <= '0;
      hi <= '0;
    end else begin
      if (R1in) r1 <= bus;
      if (R2in) r2 <= bus;
      if (R3in) r3 <= bus;
      if (Yin)  y  <= bus;
      if (IRin) ir <= bus;
      if (HIin) hi <= bus;
    end
  end

  // PC has no load path in this slice; it only resets and holds
  always_ff @(posedge clock or posedge clear) begin
    if (clear) pc <= '0;
    else       pc <= pc;
  end

  // Z captures the zero-extended ALU result when AND is asserted
  always_ff @(posedge clock or posedge clear) begin
    if (clear)    z <= '0;
    else if (AND) z <= {32'h0, alu_and};
  end

  // Observation outputs
  always_comb begin
    BusMuxOut = bus;
    R1_q      = r1;
    R2_q      = r2;
    R3_q      = r3;
    IR_q      = ir;
    HI_q      = hi;
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed register-transfer sequences plus random strobe
// traffic, all checked against a behavioural register-file model.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic [15:0] ctl;
  logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, IR_q, HI_q;

  localparam int C_READ = 0, C_MDRIN = 1, C_MDROUT = 2, C_R2OUT = 3, C_R3OUT = 4,
                 C_PCOUT = 5, C_ZLO = 6, C_ZHI = 7, C_R1IN = 8, C_R2IN = 9,
                 C_R3IN = 10, C_YIN = 11, C_IRIN = 12, C_HIIN = 13, C_AND = 14;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state
  logic [31:0] m_mdr, m_r1, m_r2, m_r3, m_ir, m_y, m_hi;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  datapath dut (
    .clock    (clock),
    .clear    (clear),
    .Mdatain  (Mdatain),
    .Read     (ctl[C_READ]),
    .MDRin    (ctl[C_MDRIN]),
    .MDRout   (ctl[C_MDROUT]),
    .R2out    (ctl[C_R2OUT]),
    .R3out    (ctl[C_R3OUT]),
    .PCout    (ctl[C_PCOUT]),
    .Zlowout  (ctl[C_ZLO]),
    .ZHighout (ctl[C_ZHI]),
    .R1in     (ctl[C_R1IN]),
    .R2in     (ctl[C_R2IN]),
    .R3in     (ctl[C_R3IN]),
    .Yin      (ctl[C_YIN]),
    .IRin     (ctl[C_IRIN]),
    .HIin     (ctl[C_HIIN]),
    .AND      (ctl[C_AND]),
    .BusMuxOut(BusMuxOut),
    .R1_q     (R1_q),
    .R2_q     (R2_q),
    .R3_q     (R3_q),
    .IR_q     (IR_q),
    .HI_q     (HI_q)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus value from the priority-ordered source list (PC is always zero here)
  function automatic logic [31:0] ref_bus(input logic [15:0] c);
    logic [31:0] src [6];
    int unsigned sel [6];
    src = '{m_mdr, m_r2, m_r3, 32'h0, m_z[31:0], m_z[63:32]};
    sel = '{C_MDROUT, C_R2OUT, C_R3OUT, C_PCOUT, C_ZLO, C_ZHI};
    for (int i = 0; i < 6; i++)
      if (c[sel[i]]) return src[i];
    return 32'h0;
  endfunction

  task automatic model_reset();
    {m_mdr, m_r1, m_r2, m_r3, m_ir, m_y, m_hi} = '0;
    m_z = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".R1"}, {32'h0, R1_q}, {32'h0, m_r1});
    check({tag, ".R2"}, {32'h0, R2_q}, {32'h0, m_r2});
    check({tag, ".R3"}, {32'h0, R3_q}, {32'h0, m_r3});
    check({tag, ".IR"}, {32'h0, IR_q}, {32'h0, m_ir});
    check({tag, ".HI"}, {32'h0, HI_q}, {32'h0, m_hi});
  endtask

  // One bus cycle: drive strobes after an edge, check bus, clock, check registers
  task automatic cycle(input logic [15:0] c, input logic [31:0] md, input string tag);
    logic [31:0] b;
    ctl = c;
    Mdatain = md;
    #1;
    b = ref_bus(c);
    check({tag, ".bus"}, {32'h0, BusMuxOut}, {32'h0, b});
    @(posedge clock);
    if (c[C_AND])   m_z   = {32'h0, m_y & b};
    if (c[C_MDRIN]) m_mdr = c[C_READ] ? md : b;
    if (c[C_R1IN])  m_r1  = b;
    if (c[C_R2IN])  m_r2  = b;
    if (c[C_R3IN])  m_r3  = b;
    if (c[C_YIN])   m_y   = b;
    if (c[C_IRIN])  m_ir  = b;
    if (c[C_HIIN])  m_hi  = b;
    #1;
    check_regs(tag);
  endtask

  function automatic logic [15:0] bits(input int unsigned a, input int unsigned b = 15,
                                       input int unsigned d = 15);
    logic [15:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    v[d] = 1'b1;
    v[15] = 1'b0;
    return v;
  endfunction

  initial begin
    ctl = '0;
    Mdatain = '0;
    clear = 1'b1;
    model_reset();
    #3;
    check_regs("reset");
    check("reset.bus", {32'h0, BusMuxOut}, 64'h0);
    @(posedge clock);
    #1 clear = 1'b0;

    // Register loads via MDR
    cycle(bits(C_READ, C_MDRIN), 32'h12, "ld_mdr12");
    cycle(bits(C_MDROUT, C_R2IN), 32'h11, "mdr_r2");
    check("R2_is_12", {32'h0, R2_q}, 64'h12);
    cycle(bits(C_READ, C_MDRIN), 32'h14, "ld_mdr14");
    cycle(bits(C_MDROUT, C_R3IN), 32'h0, "mdr_r3");
    check("R3_is_14", {32'h0, R3_q}, 64'h14);
    cycle(bits(C_READ, C_MDRIN), 32'h18, "ld_mdr18");
    cycle(bits(C_MDROUT, C_R1IN), 32'h0, "mdr_r1");
    check("R1_is_18", {32'h0, R1_q}, 64'h18);

    // Instruction fetch
    cycle(bits(C_READ, C_MDRIN), 32'h7, "ld_mdr7");
    cycle(bits(C_MDROUT, C_IRIN), 32'h0, "mdr_ir");
    check("IR_is_7", {32'h0, IR_q}, 64'h7);

    // AND: Y <= R2, Z <= Y & R3, R1 <= Zlo, HI <= Zhi
    cycle(bits(C_R2OUT, C_YIN), 32'h0, "r2_y");
    cycle(bits(C_R3OUT, C_AND), 32'h0, "and");
    cycle(bits(C_ZLO, C_R1IN), 32'h0, "zlo_r1");
    check("R1_is_10", {32'h0, R1_q}, 64'h10);
    cycle(bits(C_ZHI, C_HIIN), 32'h0, "zhi_hi");
    check("HI_is_0", {32'h0, HI_q}, 64'h0);

    // Priority: MDR (0x7) wins over R2 (0x12)
    ctl = bits(C_MDROUT, C_R2OUT);
    #1 check("prio_mdr", {32'h0, BusMuxOut}, 64'h7);
    ctl = bits(C_R2OUT, C_R3OUT, C_ZLO);
    #1 check("prio_r2", {32'h0, BusMuxOut}, 64'h12);
    ctl = bits(C_PCOUT, C_ZLO);
    #1 check("prio_pc", {32'h0, BusMuxOut}, 64'h0);
    ctl = '0;
    #1 check("idle_bus", {32'h0, BusMuxOut}, 64'h0);
    @(posedge clock);
    #1;

    // AND low with Y and bus changing: Z must hold 0x10
    cycle(bits(C_MDROUT, C_YIN), 32'h0, "y_chg");
    cycle(bits(C_R2OUT), 32'h0, "noand");
    cycle(bits(C_ZLO), 32'h0, "zhold");
    ctl = bits(C_ZLO);
    #1 check("z_held", {32'h0, BusMuxOut}, 64'h10);

    // Random traffic
    for (int unsigned n = 0; n < 400; n++) begin
      logic [15:0] c;
      c = 16'($urandom) & 16'h7FFF;
      if ($urandom_range(0, 1) == 0) c[7:2] = 6'($urandom) & 6'($urandom);
      cycle(c, $urandom, "rand");
    end

    // Asynchronous clear mid-cycle, with drive strobes active
    ctl = bits(C_MDROUT);
    #2;
    clear = 1'b1;
    model_reset();
    #1;
    check_regs("clr_async");
    check("clr_async.bus", {32'h0, BusMuxOut}, 64'h0);
    ctl = bits(C_ZLO);
    #1 check("clr_zlo", {32'h0, BusMuxOut}, 64'h0);
    // Clear dominates loads across an edge
    ctl = bits(C_READ, C_MDRIN, C_R1IN) | bits(C_R2IN, C_IRIN, C_HIIN) | bits(C_YIN, C_AND);
    Mdatain = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    check_regs("clr_hold");
    ctl = bits(C_MDROUT);
    #1 check("clr_hold.mdr", {32'h0, BusMuxOut}, 64'h0);
    ctl = '0;
    #1 clear = 1'b0;
    cycle(bits(C_READ, C_MDRIN), 32'hA5A5_0001, "post_clr");
    cycle(bits(C_MDROUT, C_R3IN), 32'h0, "post_clr_r3");
    check("R3_post_clr", {32'h0, R3_q}, 64'hA5A5_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
